mult_tree_sched: RTL

Round-robin scheduler that shares one fixed-latency 4-operand multiply tree between N_REQ requesters. The tree is not replicated. Each requester gets a valid/ready issue port and a response pulse. The block tracks every in-flight operation with a tag shift register aligned to the datapath latency, and routes each 8-bit result back to its owner. It sits between the requester logic and the tree instance, and drives the tree's operand inputs directly.

---
 rtl/mult_tree_sched.sv | 86 ++++++++
 1 files changed

// File: rtl/mult_tree_sched.sv
// mult_tree_sched: round-robin issue of N_REQ requesters onto one shared fixed-latency multiply tree,
// with a tag pipeline aligned to the tree latency that routes each result back to its owner.
module mult_tree_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [4*N_REQ-1:0] req_b,
    input  logic [4*N_REQ-1:0] req_c,
    input  logic [4*N_REQ-1:0] req_d,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_data,
    output logic [3:0]         m_a,
    output logic [3:0]         m_b,
    output logic [3:0]         m_c,
    output logic [3:0]         m_d,
    input  logic [7:0]         m_result,
    output logic               busy
);
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             tag_v  [0:LAT];
    logic [ID_W-1:0]  tag_id [0:LAT];

    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v % N_REQ);
    endfunction

    // a requester whose result returns this cycle may reissue immediately
    assign elig      = req_valid & (~pending | rsp_valid) & {N_REQ{~rst}};
    assign rsp_valid = (tag_v[LAT] && !rst) ? N_REQ'(1) << tag_id[LAT] : '0;
    assign rsp_data  = m_result;
    assign busy      = |pending & ~rst;
    assign req_ready = grant;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[wrap(int'(rr_ptr) + k)]) begin
                found = 1'b1;
                win   = wrap(int'(rr_ptr) + k);
            end
        end
        grant = found ? N_REQ'(1) << win : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            rr_ptr  <= '0;
            m_a     <= '0;
            m_b     <= '0;
            m_c     <= '0;
            m_d     <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            pending   <= (pending & ~rsp_valid) | grant;
            tag_v[0]  <= found;
            tag_id[0] <= win;
            for (int k = 1; k <= LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (found) begin
                rr_ptr <= wrap(int'(win) + 1);
                m_a    <= req_a[4*win +: 4];
                m_b    <= req_b[4*win +: 4];
                m_c    <= req_c[4*win +: 4];
                m_d    <= req_d[4*win +: 4];
            end
        end
    end
endmodule
